// File: rtl/tx_sched_pkg.sv
// ---------------------------------------------------------------------------
// tx_sched_pkg
// Shared types and defaults for the outbound status-byte scheduler.
//   state_t      : handshake FSM states (IDLE, LOAD, WAIT_DONE, GAP)
//   byte_t       : one UART payload byte
//   DEF_*        : default parameter values used by tx_msg_sched/rr_arbiter
//   rr_wrap_inc  : index + 1 modulo n, used to advance the round-robin pointer
// ---------------------------------------------------------------------------
package tx_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LOAD      = 2'd1,
    ST_WAIT_DONE = 2'd2,
    ST_GAP       = 2'd3
  } state_t;

  typedef logic [7:0] byte_t;

  localparam int DEF_NUM_REQ    = 3;
  localparam int DEF_GAP_CYCLES = 2;
  localparam int DEF_TX_TIMEOUT = 65535;

  function automatic int rr_wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/tx_msg_sched_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin pick: the first set bit of i_pending at or
// after i_ptr, wrapping past the top index back to 0.
// Ports:
//   i_pending [NUM_REQ]  request vector (holding registers occupied)
//   i_ptr     [IDX_W]    index with highest priority this round
//   o_grant   [NUM_REQ]  one-hot grant (all zero when nothing pending)
//   o_idx     [IDX_W]    binary index of the granted requester
//   o_any                at least one requester pending
// ---------------------------------------------------------------------------
module rr_arbiter
  import tx_sched_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] i_pending,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [IDX_W-1:0]   o_idx,
  output logic               o_any
);

  always_comb begin
    int  w_cand;
    logic w_found;
    o_grant = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_cand  = 0;
    // Scan NUM_REQ slots starting at the pointer; the first hit wins.
    for (int k = 0; k < NUM_REQ; k++) begin
      w_cand = int'(i_ptr) + k;
      if (w_cand >= NUM_REQ) begin
        w_cand = w_cand - NUM_REQ;
      end
      if (!w_found && i_pending[w_cand[IDX_W-1:0]]) begin
        w_found                    = 1'b1;
        o_grant[w_cand[IDX_W-1:0]] = 1'b1;
        o_idx                      = w_cand[IDX_W-1:0];
      end
    end
    o_any = w_found;
  end

endmodule

// File: rtl/tx_msg_sched.sv
// ---------------------------------------------------------------------------
// tx_msg_sched
// Buffers one status byte per requester and feeds them, round-robin, to the
// shared UART transmitter. Sequences trmt/tx_done, leaves GAP_CYCLES idle
// clocks between frames and drops a frame whose tx_done never arrives.
//
// Handshake: a requester posts by pulsing req[i] with its byte on
// req_data[8i+7:8i]. The post is accepted when holding register i is empty
// (or is being emptied in that same cycle); acceptance is reported by a
// one-cycle ack[i] on the following cycle. A post to an occupied register is
// silently ignored. done[i] pulses in the cycle the tx_done rising edge is
// seen for requester i's frame; a dropped (timed-out) frame gives no done.
//
// Ports:
//   clk, rst_n         clock, synchronous active-low reset
//   req, req_data      per-requester post strobe and bytes
//   ack, done, pending per-requester accept / completion / occupied flags
//   trmt, tx_data      start strobe and byte to UART_tx
//   tx_done            UART_tx completion level (rising edge = frame sent)
//   busy               FSM not in IDLE
//   timeout_err,clr_err sticky abandoned-frame flag and its clear
//   dbg_state          current FSM state
// ---------------------------------------------------------------------------
module tx_msg_sched
  import tx_sched_pkg::*;
#(
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int GAP_CYCLES = DEF_GAP_CYCLES,
  parameter int TX_TIMEOUT = DEF_TX_TIMEOUT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   ack,
  output logic [NUM_REQ-1:0]   done,
  output logic [NUM_REQ-1:0]   pending,
  output logic                 trmt,
  output logic [7:0]           tx_data,
  input  logic                 tx_done,
  output logic                 busy,
  output logic                 timeout_err,
  input  logic                 clr_err,
  output state_t               dbg_state
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(TX_TIMEOUT + 1);
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  // Last WAIT_DONE cycle before the frame is abandoned, and last GAP cycle.
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TX_TIMEOUT - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

  // FSM
  state_t r_state;
  state_t w_state_nxt;

  // Datapath registers
  byte_t              r_hold [NUM_REQ];
  logic [NUM_REQ-1:0] r_pending;
  logic [NUM_REQ-1:0] r_ack;
  logic               r_trmt;
  byte_t              r_tx_data;
  logic [IDX_W-1:0]   r_ptr;
  logic [IDX_W-1:0]   r_gnt_idx;
  logic [CNT_W-1:0]   r_cnt;
  logic [GAP_W-1:0]   r_gap;
  logic               r_tx_done_q;
  logic               r_timeout_err;

  // Combinational helpers
  logic [NUM_REQ-1:0] w_arb_grant;
  logic [IDX_W-1:0]   w_arb_idx;
  logic               w_arb_any;
  logic               w_tx_edge;
  logic               w_frame_ok;
  logic               w_frame_to;
  logic               w_frame_end;
  logic               w_grant_now;
  logic [NUM_REQ-1:0] w_gnt_vec;
  logic [NUM_REQ-1:0] w_clr_vec;
  logic [NUM_REQ-1:0] w_accept;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .i_pending (r_pending),
    .i_ptr     (r_ptr),
    .o_grant   (w_arb_grant),
    .o_idx     (w_arb_idx),
    .o_any     (w_arb_any)
  );

  // Only the IDLE decision consumes the arbiter; the one-hot form is kept
  // for observability of the live arbitration result.
  assign w_grant_now = (r_state == ST_IDLE) && w_arb_any && (|w_arb_grant);

  // tx_done is a level; only its 0->1 transition completes a frame.
  assign w_tx_edge   = tx_done & ~r_tx_done_q;
  assign w_frame_ok  = (r_state == ST_WAIT_DONE) && w_tx_edge;
  assign w_frame_to  = (r_state == ST_WAIT_DONE) && !w_tx_edge && (r_cnt == TO_LAST);
  assign w_frame_end = w_frame_ok | w_frame_to;

  assign w_gnt_vec = NUM_REQ'(1) << r_gnt_idx;
  assign w_clr_vec = w_frame_end ? w_gnt_vec : '0;

  // A register being emptied this cycle can take a new byte: set wins.
  assign w_accept  = req & (~r_pending | w_clr_vec);

  // -------------------------------------------------------------------------
  // FSM state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // -------------------------------------------------------------------------
  // FSM next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_grant_now) begin
          w_state_nxt = ST_LOAD;
        end
      end
      ST_LOAD: begin
        w_state_nxt = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (w_frame_end) begin
          w_state_nxt = ST_GAP;
        end
      end
      ST_GAP: begin
        if (r_gap == GAP_LAST) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Holding registers: written only on an accepted post, so a post to one
  // requester never touches the byte already latched into tx_data.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        r_hold[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (w_accept[i]) begin
          r_hold[i] <= req_data[8*i +: 8];
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Flags, strobes, counters and round-robin pointer
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pending     <= '0;
      r_ack         <= '0;
      r_trmt        <= 1'b0;
      r_tx_data     <= '0;
      r_ptr         <= '0;
      r_gnt_idx     <= '0;
      r_cnt         <= '0;
      r_gap         <= '0;
      r_tx_done_q   <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_ack       <= w_accept;
      r_pending   <= (r_pending & ~w_clr_vec) | w_accept;
      r_tx_done_q <= tx_done;

      // trmt is registered off LOAD so it lands in the first WAIT_DONE cycle
      // with tx_data already stable for a full clock.
      r_trmt <= (r_state == ST_LOAD);

      // tx_data and the grant index are captured once per frame, in IDLE.
      if (w_grant_now) begin
        r_tx_data <= r_hold[w_arb_idx];
        r_gnt_idx <= w_arb_idx;
      end

      if (r_state == ST_LOAD) begin
        r_cnt <= '0;
      end else if ((r_state == ST_WAIT_DONE) && !w_frame_end) begin
        r_cnt <= r_cnt + 1'b1;
      end

      if ((r_state == ST_GAP) && (r_gap != GAP_LAST)) begin
        r_gap <= r_gap + 1'b1;
      end else begin
        r_gap <= '0;
      end

      // Pointer moves past the served requester whether it succeeded or not.
      if (w_frame_end) begin
        r_ptr <= IDX_W'(rr_wrap_inc(int'(r_gnt_idx), NUM_REQ));
      end

      if (w_frame_to) begin
        r_timeout_err <= 1'b1;
      end else if (clr_err) begin
        r_timeout_err <= 1'b0;
      end
    end
  end

  assign ack         = r_ack;
  assign pending     = r_pending;
  assign done        = w_frame_ok ? w_gnt_vec : '0;
  assign trmt        = r_trmt;
  assign tx_data     = r_tx_data;
  assign busy        = (r_state != ST_IDLE);
  assign timeout_err = r_timeout_err;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_tx_msg_sched.sv
// ---------------------------------------------------------------------------
// tb_tx_msg_sched
// Directed bench for tx_msg_sched (NUM_REQ=3, GAP_CYCLES=2, TX_TIMEOUT=50).
// Expected bytes are queued in exp_q when posted and popped when trmt fires.
// ---------------------------------------------------------------------------
module tb_tx_msg_sched;
  import tx_sched_pkg::*;

  localparam int N_REQ   = 3;
  localparam int GAP     = 2;
  localparam int TIMEOUT = 50;

  // Clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [N_REQ-1:0]   req;
  logic [8*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]   ack;
  logic [N_REQ-1:0]   done;
  logic [N_REQ-1:0]   pending;
  logic               trmt;
  logic [7:0]         tx_data;
  logic               tx_done;
  logic               busy;
  logic               timeout_err;
  logic               clr_err;
  state_t             dbg_state;

  tx_msg_sched #(
    .NUM_REQ    (N_REQ),
    .GAP_CYCLES (GAP),
    .TX_TIMEOUT (TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .req_data    (req_data),
    .ack         (ack),
    .done        (done),
    .pending     (pending),
    .trmt        (trmt),
    .tx_data     (tx_data),
    .tx_done     (tx_done),
    .busy        (busy),
    .timeout_err (timeout_err),
    .clr_err     (clr_err),
    .dbg_state   (dbg_state)
  );

  // Scoreboard
  logic [7:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic post(input logic [2:0] mask, input logic [23:0] data);
    req      = mask;
    req_data = data;
    tick();
    req      = '0;
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    req      = '0;
    req_data = '0;
    tx_done  = 1'b0;
    clr_err  = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Wait (bounded) for trmt, then check the byte against the scoreboard.
  task automatic wait_trmt(output bit seen, output logic [7:0] exp_b);
    int n;
    n     = 0;
    exp_b = 8'h00;
    while (trmt !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    seen = (trmt === 1'b1);
    chk("trmt_seen", 32'(seen), 1);
    if (seen) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_frame", 32'(exp_q.size()), 1);
      end else begin
        exp_b = exp_q.pop_front();
        chk("tx_data", 32'(tx_data), 32'(exp_b));
      end
    end
  endtask

  // Play UART_tx for one frame: tx_done rises after 'delay' extra cycles.
  // coll_mask/coll_data post in the same cycle the done pulse is seen.
  task automatic serve(input logic [2:0] exp_done, input int delay,
                       input logic [2:0] exp_pend, input logic [2:0] coll_mask,
                       input logic [23:0] coll_data);
    bit         seen;
    logic [7:0] exp_b;
    wait_trmt(seen, exp_b);
    if (seen) begin
      tick();
      chk("trmt_one_cycle", 32'(trmt), 0);
      repeat (delay) tick();
      chk("tx_data_stable", 32'(tx_data), 32'(exp_b));
      chk("no_early_done", 32'(done), 0);
      tx_done  = 1'b1;
      req      = coll_mask;
      req_data = coll_data;
      #1;
      chk("done_pulse", 32'(done), 32'(exp_done));
      tick();
      chk("done_one_cycle", 32'(done), 0);
      chk("coll_ack", 32'(ack), 32'(coll_mask));
      chk("pend_after_done", 32'(pending), 32'(exp_pend));
      req     = '0;
      tx_done = 1'b0;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit         seen;
    logic [7:0] exp_b;
    int         n;
    int         trmt_cnt;
    bit         saw_done;

    // ---------------- reset state ----------------
    do_reset();
    rst_n = 1'b0;
    tick();
    chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    chk("rst_pending", 32'(pending), 0);
    chk("rst_ack", 32'(ack), 0);
    chk("rst_trmt", 32'(trmt), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_tx_data", 32'(tx_data), 0);
    chk("rst_err", 32'(timeout_err), 0);
    chk("rst_done", 32'(done), 0);
    rst_n = 1'b1;
    tick();

    // ---------------- single post ----------------
    exp_q.push_back(8'hA5);
    post(3'b010, {8'h00, 8'hA5, 8'h00});
    chk("t1_ack", 32'(ack), 'b010);
    chk("t1_pending", 32'(pending), 'b010);
    chk("t1_trmt_early", 32'(trmt), 0);
    tick();
    chk("t1_ack_pulse", 32'(ack), 0);
    chk("t1_busy_load", 32'(busy), 1);
    chk("t1_state_load", 32'(dbg_state), 32'(ST_LOAD));
    chk("t1_trmt_load", 32'(trmt), 0);
    tick();
    chk("t1_trmt_k3", 32'(trmt), 1);
    serve(3'b010, 2, 3'b000, 3'b000, 24'h0);
    chk("t1_busy_gap1", 32'(busy), 1);
    tick();
    chk("t1_busy_gap2", 32'(busy), 1);
    tick();
    chk("t1_busy_idle", 32'(busy), 0);

    // ---------------- round robin ----------------
    do_reset();
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    exp_q.push_back(8'h33);
    post(3'b111, {8'h33, 8'h22, 8'h11});
    chk("rr_ack", 32'(ack), 'b111);
    serve(3'b001, 1, 3'b110, 3'b000, 24'h0);
    serve(3'b010, 1, 3'b100, 3'b000, 24'h0);
    serve(3'b100, 1, 3'b000, 3'b000, 24'h0);
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    exp_q.push_back(8'h33);
    post(3'b111, {8'h33, 8'h22, 8'h11});
    chk("rr2_ack", 32'(ack), 'b111);
    serve(3'b001, 0, 3'b110, 3'b000, 24'h0);
    serve(3'b010, 0, 3'b100, 3'b000, 24'h0);
    serve(3'b100, 0, 3'b000, 3'b000, 24'h0);

    // ---------------- busy rejection ----------------
    repeat (2) tick();
    exp_q.push_back(8'h40);
    post(3'b001, {16'h0, 8'h40});
    chk("rej_ack1", 32'(ack), 'b001);
    post(3'b001, {16'h0, 8'h41});
    chk("rej_no_ack", 32'(ack), 0);
    chk("rej_pending", 32'(pending), 'b001);
    serve(3'b001, 2, 3'b000, 3'b000, 24'h0);
    trmt_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (trmt === 1'b1) trmt_cnt++;
    end
    chk("rej_no_second_frame", 32'(trmt_cnt), 0);

    // ---------------- clear/post collision ----------------
    exp_q.push_back(8'h55);
    exp_q.push_back(8'h7E);
    post(3'b100, {8'h55, 16'h0});
    chk("col_ack", 32'(ack), 'b100);
    serve(3'b100, 1, 3'b100, 3'b100, {8'h7E, 16'h0});
    serve(3'b100, 1, 3'b000, 3'b000, 24'h0);

    // ---------------- timeout ----------------
    exp_q.push_back(8'hB1);
    exp_q.push_back(8'hB2);
    post(3'b011, {8'h00, 8'hB2, 8'hB1});
    chk("to_ack", 32'(ack), 'b011);
    wait_trmt(seen, exp_b);
    n        = 0;
    saw_done = 1'b0;
    while (timeout_err !== 1'b1 && n < 80) begin
      tick();
      n++;
      if (done !== '0) saw_done = 1'b1;
    end
    chk("to_latency", 32'(n), 50);
    chk("to_no_done", 32'(saw_done), 0);
    chk("to_pending", 32'(pending), 'b010);
    chk("to_busy_gap", 32'(busy), 1);
    serve(3'b010, 1, 3'b000, 3'b000, 24'h0);
    chk("to_err_sticky", 32'(timeout_err), 1);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("to_err_cleared", 32'(timeout_err), 0);

    // clr_err in the very cycle a new timeout fires: set wins
    exp_q.push_back(8'hC3);
    post(3'b001, {16'h0, 8'hC3});
    wait_trmt(seen, exp_b);
    repeat (49) tick();
    chk("co_err_before", 32'(timeout_err), 0);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("co_err_set_wins", 32'(timeout_err), 1);
    chk("co_pending", 32'(pending), 0);

    // ---------------- reset mid-frame ----------------
    exp_q.push_back(8'hD4);
    post(3'b010, {8'h00, 8'hD4, 8'h00});
    wait_trmt(seen, exp_b);
    tick();
    chk("mr_in_wait", 32'(dbg_state), 32'(ST_WAIT_DONE));
    rst_n = 1'b0;
    tick();
    chk("mr_state", 32'(dbg_state), 32'(ST_IDLE));
    chk("mr_pending", 32'(pending), 0);
    chk("mr_ack", 32'(ack), 0);
    chk("mr_trmt", 32'(trmt), 0);
    chk("mr_busy", 32'(busy), 0);
    chk("mr_tx_data", 32'(tx_data), 0);
    chk("mr_err", 32'(timeout_err), 0);
    chk("mr_done", 32'(done), 0);
    rst_n = 1'b1;
    tick();
    exp_q.push_back(8'hE5);
    post(3'b100, {8'hE5, 16'h0});
    chk("mr_post_ack", 32'(ack), 'b100);
    serve(3'b100, 1, 3'b000, 3'b000, 24'h0);
    repeat (3) tick();
    chk("end_busy", 32'(busy), 0);
    chk("end_exp_q_empty", 32'(exp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/tx_msg_sched.md
Name: tx_msg_sched

Overview:
Schedules outbound status bytes (station-arrival report, command acknowledge, obstacle/buzz alert, etc.) from several robot-side requesters onto the single shared UART_tx transmitter. Each requester posts one byte. The block buffers one byte per requester and grants the transmitter round-robin. It sequences the trmt/tx_done handshake, enforces an inter-frame gap and recovers from a hung transmitter. It sits between the command FSM / barcode logic and UART_tx.

Parameters:
NUM_REQ, 3, number of requesters (2..8)
GAP_CYCLES, 2, idle clocks inserted after each frame before the next grant (>=1)
TX_TIMEOUT, 65535, clocks to wait for tx_done before abandoning a frame; counter width = $clog2(TX_TIMEOUT+1)

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
req  in  NUM_REQ  per-requester post strobe (one-cycle pulse)
req_data  in  8*NUM_REQ  byte for requester i at [8i+7:8i], sampled when req[i]=1
ack  out  NUM_REQ  one-cycle pulse: post accepted into holding register
done  out  NUM_REQ  one-cycle pulse: requester's byte fully transmitted
pending  out  NUM_REQ  holding register i occupied
trmt  out  1  start strobe to UART_tx
tx_data  out  8  byte to UART_tx
tx_done  in  1  UART_tx completion (level; rising edge is the event)
busy  out  1  high in any state other than IDLE
timeout_err  out  1  sticky: a frame was abandoned
clr_err  in  1  clears timeout_err

Behaviour:
- Reset (synchronous on rst_n=0, also mid-frame): state=IDLE; pending, ack, done, trmt, busy, timeout_err all 0; tx_data=8'h00; RR pointer=0; timeout and gap counters=0; tx_done edge register=0.
- Post: req[i]=1 with pending[i]=0 -> hold_i<=req_data[i], pending[i]=1 and ack[i]=1 on the next cycle. req[i]=1 with pending[i]=1 -> ignored, no ack, held data unchanged.
- Same cycle as pending[i] clears (done or timeout): a new req[i] is accepted (set wins), ack[i] pulses.
- FSM states: IDLE, LOAD, WAIT_DONE, GAP.
- IDLE: if any pending, grant g = first pending index at or after RR pointer, wrapping. tx_data<=hold_g. -> LOAD.
- Latency: req in cycle k -> pending at k+1 -> trmt high at k+3 when the block was idle.
- LOAD: trmt=1 for exactly one cycle; timeout counter cleared. -> WAIT_DONE.
- tx_data stays stable from LOAD until WAIT_DONE exits.
- WAIT_DONE on tx_done rising edge (tx_done=1 with registered previous value 0): pending[g]=0, done[g] pulse, RR pointer=g+1 mod NUM_REQ. -> GAP.
- WAIT_DONE when the counter reaches TX_TIMEOUT with no edge: pending[g]=0 (byte dropped), no done pulse, timeout_err=1, pointer advances as above. -> GAP.
- GAP: count GAP_CYCLES clocks. -> IDLE.
- Posts during LOAD, WAIT_DONE or GAP are accepted normally. They are not granted before IDLE.
- clr_err=1 clears timeout_err. If clr_err and a timeout occur in the same cycle, set wins.
- Fairness: with all requesters continuously pending, grants cycle 0,1,2,0,...; no requester waits more than NUM_REQ frames.
- Only the granted holding register is read; a new post to a different requester never disturbs tx_data.

Decomposition:
- tx_sched_pkg: state enum (IDLE, LOAD, WAIT_DONE, GAP), byte typedef, default GAP_CYCLES/TX_TIMEOUT constants.
- One sub-module: rr_arbiter. Combinational; inputs pending vector and pointer; outputs one-hot grant, binary index and any_valid.
- Holding registers, handshake FSM and counters live in tx_msg_sched.

Test Plan:
- Single post: req[1]=1, data 8'hA5 while idle -> ack[1] next cycle. trmt one cycle 2 cycles later with tx_data=8'hA5. The UART_rx loopback receives 8'hA5. done[1] on tx_done edge. busy low after GAP_CYCLES.
- Round-robin: post 8'h11, 8'h22, 8'h33 to requesters 0..2 in the same cycle -> transmitted in order 11, 22, 33. Re-post all three -> order 11, 22, 33 again; pointer wraps to 0.
- Busy rejection: post 8'h40 to requester 0, then 8'h41 to requester 0 while it is still pending -> no second ack; only 8'h40 is transmitted.
- Clear/post collision: requester 2 posts 8'h7E in the cycle done[2] pulses -> ack[2], pending[2] stays 1, 8'h7E sent next.
- Timeout: TX_TIMEOUT=50, tx_done held 0 -> after 50 cycles in WAIT_DONE, timeout_err=1, no done, pending cleared, next requester is served. clr_err -> timeout_err=0. clr_err coincident with a new timeout -> timeout_err stays 1.
- Reset mid-frame: rst_n=0 during WAIT_DONE -> next cycle all outputs 0, state IDLE, pending cleared. A post after release is transmitted normally.
